pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the single-register PC with branch select.
- Holds PC and computes the sequential increment internally.
- Resolves jump, conditional branch, call and return redirects with fixed priority.
- Contains a circular return-address stack (RAS) of configurable depth. Sits between the control unit (control inputs) and the memory address path (pc_q).

---
 rtl/pc_unit.sv | 140 ++++++++++++++
 tb/tb_pc_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with fixed-priority redirects and a circular return-address stack.
// Optional trace outputs (last_src, redir_cnt) are built when PC_UNIT_TRACE_EN is defined.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      INC       = 1,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               clr,
    input  logic                               enable,
    input  logic                               br_in,
    input  logic                               br_cond,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WIDTH-1:0]                   target,
    output logic [WIDTH-1:0]                   pc_q,
    output logic [WIDTH-1:0]                   pc_plus,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_cnt,
    output logic                               ras_empty,
    output logic                               ras_full,
`ifdef PC_UNIT_TRACE_EN
    output logic [WIDTH-1:0]                   last_src,
    output logic [15:0]                        redir_cnt,
`endif
    output logic                               ras_err
);

    localparam int unsigned     CW       = $clog2(RAS_DEPTH + 1);
    localparam int unsigned     PW       = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0]   PTR_MAX  = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW-1:0]    ptr_up;
    logic [PW-1:0]    ptr_dn;
    logic [PW-1:0]    ptr_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ras_top;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             err_d;

    assign pc_plus   = pc_q + WIDTH'(INC);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_FULL);

    // ras_ptr is the next free slot; the top entry sits one below it
    assign ptr_up  = (ras_ptr == PTR_MAX) ? '0 : ras_ptr + 1'b1;
    assign ptr_dn  = (ras_ptr == '0) ? PTR_MAX : ras_ptr - 1'b1;
    assign ras_top = ras_mem[ptr_dn];

    // Redirect resolution, first match wins; empty ret falls back to target
    always_comb begin
        pc_d   = pc_plus;
        ptr_d  = ras_ptr;
        cnt_d  = ras_cnt;
        err_d  = 1'b0;
        wr_en  = 1'b0;
        wr_idx = ras_ptr;
        if (ret && call) begin
            wr_en = 1'b1;
            if (!ras_empty) begin
                pc_d   = ras_top;
                wr_idx = ptr_dn;
            end else begin
                pc_d  = target;
                ptr_d = ptr_up;
                cnt_d = CW'(1);
                err_d = 1'b1;
            end
        end else if (ret) begin
            if (!ras_empty) begin
                pc_d  = ras_top;
                ptr_d = ptr_dn;
                cnt_d = ras_cnt - 1'b1;
            end else begin
                pc_d  = target;
                err_d = 1'b1;
            end
        end else if (call) begin
            pc_d  = target;
            wr_en = 1'b1;
            ptr_d = ptr_up;
            if (ras_full) begin
                err_d = 1'b1;
            end else begin
                cnt_d = ras_cnt + 1'b1;
            end
        end else if (jump || (br_in && br_cond)) begin
            pc_d = target;
        end
    end

    // PC, RAS pointer, occupancy and error pulse registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_q    <= RESET_VEC;
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_err <= 1'b0;
        end else if (enable) begin
            pc_q    <= pc_d;
            ras_ptr <= ptr_d;
            ras_cnt <= cnt_d;
            ras_err <= err_d;
        end else begin
            ras_err <= 1'b0;
        end
    end

    // RAS storage; contents need no reset since ras_cnt gates every read
    always_ff @(posedge clk) begin
        if (enable && wr_en) begin
            ras_mem[wr_idx] <= pc_plus;
        end
    end

`ifdef PC_UNIT_TRACE_EN
    logic redir;
    assign redir = ret || call || jump || (br_in && br_cond);

    // Source PC of the latest taken redirect and a saturating redirect count
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_src  <= '0;
            redir_cnt <= '0;
        end else if (enable && redir) begin
            last_src <= pc_q;
            if (redir_cnt != 16'hFFFF) begin
                redir_cnt <= redir_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus random control traffic against a queue-based model.
// Trace outputs are also checked when PC_UNIT_TRACE_EN is defined.
module tb_pc_unit;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        clr;
    logic        enable;
    logic        br_in;
    logic        br_cond;
    logic        jump;
    logic        call;
    logic        ret;
    logic [31:0] target;
    logic [31:0] pc_q;
    logic [31:0] pc_plus;
    logic [2:0]  ras_cnt;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;
`ifdef PC_UNIT_TRACE_EN
    logic [31:0] last_src;
    logic [15:0] redir_cnt;
`endif

    pc_unit #(
        .WIDTH(32),
        .RESET_VEC(RV),
        .INC(1),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .clr(clr),
        .enable(enable),
        .br_in(br_in),
        .br_cond(br_cond),
        .jump(jump),
        .call(call),
        .ret(ret),
        .target(target),
        .pc_q(pc_q),
        .pc_plus(pc_plus),
        .ras_cnt(ras_cnt),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
`ifdef PC_UNIT_TRACE_EN
        .last_src(last_src),
        .redir_cnt(redir_cnt),
`endif
        .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // model: return addresses, newest at the back
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_err;
    logic [31:0] m_last;
    int          m_rc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RV;
        m_ras  = {};
        m_err  = 1'b0;
        m_last = '0;
        m_rc   = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"}, pc_q, m_pc);
        check({tag, ".plus"}, pc_plus, m_pc + 32'd1);
        check({tag, ".cnt"}, 32'(ras_cnt), 32'(m_ras.size()));
        check({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
        check({tag, ".full"}, 32'(ras_full), 32'(m_ras.size() == DEPTH));
        check({tag, ".err"}, 32'(ras_err), 32'(m_err));
`ifdef PC_UNIT_TRACE_EN
        check({tag, ".last"}, last_src, m_last);
        check({tag, ".rcnt"}, 32'(redir_cnt), 32'(m_rc));
`endif
    endtask

    // one clock: drive controls, advance the model, compare after the edge
    task automatic cyc(input string tag, input logic en, input logic bi,
                       input logic bc, input logic j, input logic c,
                       input logic r, input logic [31:0] tgt);
        logic [31:0] nxt;
        logic        taken;
        enable  = en;
        br_in   = bi;
        br_cond = bc;
        jump    = j;
        call    = c;
        ret     = r;
        target  = tgt;
        nxt     = m_pc + 32'd1;
        taken   = r || c || j || (bi && bc);
        m_err   = 1'b0;
        if (en) begin
            if (r && c) begin
                if (m_ras.size() > 0) begin
                    nxt = m_ras[$];
                    m_ras[m_ras.size() - 1] = m_pc + 32'd1;
                end else begin
                    nxt = tgt;
                    m_ras.push_back(m_pc + 32'd1);
                    m_err = 1'b1;
                end
            end else if (r) begin
                if (m_ras.size() > 0) begin
                    nxt = m_ras.pop_back();
                end else begin
                    nxt = tgt;
                    m_err = 1'b1;
                end
            end else if (c) begin
                nxt = tgt;
                m_ras.push_back(m_pc + 32'd1);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
            end else if (j || (bi && bc)) begin
                nxt = tgt;
            end
            if (taken) begin
                m_last = m_pc;
                if (m_rc < 16'hFFFF) m_rc++;
            end
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        clr     = 1'b0;
        enable  = 1'b0;
        br_in   = 1'b0;
        br_cond = 1'b0;
        jump    = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        target  = '0;
        model_reset();
        #12;
        compare_all("reset");
        clr = 1'b1;

        // sequential after reset
        for (int i = 0; i < 3; i++) cyc("seq", 1, 0, 0, 0, 0, 0, 32'h0);
        check("seq_end", pc_q, 32'h103);

        // branches and stall
        cyc("j10", 1, 0, 0, 1, 0, 0, 32'h10);
        cyc("bnt", 1, 1, 0, 0, 0, 0, 32'h77);
        check("bnt_val", pc_q, 32'h11);
        cyc("bt", 1, 1, 1, 0, 0, 0, 32'h40);
        cyc("stall", 0, 1, 1, 1, 1, 0, 32'h99);
        cyc("stall", 0, 0, 0, 0, 0, 1, 32'h99);
        check("stall_val", pc_q, 32'h40);

        // nested calls, returns, empty-ret fallback
        cyc("j20", 1, 0, 0, 1, 0, 0, 32'h20);
        cyc("call1", 1, 0, 0, 0, 1, 0, 32'h80);
        cyc("call2", 1, 0, 0, 0, 1, 0, 32'h90);
        cyc("ret1", 1, 0, 0, 0, 0, 1, 32'h0);
        check("ret1_val", pc_q, 32'h81);
        cyc("ret2", 1, 0, 0, 0, 0, 1, 32'h0);
        check("ret2_val", pc_q, 32'h21);
        cyc("ret3", 1, 0, 0, 0, 0, 1, 32'h5);
        check("ret3_err", 32'(ras_err), 32'h1);
        cyc("post", 1, 0, 0, 0, 0, 0, 32'h0);

        // overflow: 5 calls into a 4-deep RAS
        cyc("j1", 1, 0, 0, 1, 0, 0, 32'h1);
        for (int i = 2; i <= 6; i++) cyc("ovf", 1, 0, 0, 0, 1, 0, 32'(i));
        check("ovf_err", 32'(ras_err), 32'h1);
        for (int i = 0; i < 4; i++) cyc("unw", 1, 0, 0, 0, 0, 1, 32'h0);
        check("unw_val", pc_q, 32'h3);

        // tail call
        cyc("j30", 1, 0, 0, 1, 0, 0, 32'h30);
        cyc("c50", 1, 0, 0, 0, 1, 0, 32'h50);
        cyc("tail", 1, 0, 0, 0, 1, 1, 32'hAA);
        check("tail_val", pc_q, 32'h31);
        cyc("tret", 1, 0, 0, 0, 0, 1, 32'h0);
        check("tret_val", pc_q, 32'h51);

        // wrap
        cyc("jmax", 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
        cyc("wrap", 1, 0, 0, 0, 0, 0, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] k;
            k = 4'($urandom_range(0, 15));
            cyc("rnd", ($urandom_range(0, 9) != 0),
                k[0] & k[1], 1'($urandom), (k == 4'd5),
                (k >= 4'd10) && (k <= 4'd12), (k >= 4'd12),
                $urandom);
        end

        // asynchronous reset mid-cycle during a call
        cyc("pre", 1, 0, 0, 0, 1, 0, 32'h200);
        enable = 1'b1;
        call   = 1'b1;
        target = 32'h300;
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        check("arst.pc", pc_q, RV);
        check("arst.cnt", 32'(ras_cnt), 32'h0);
        call = 1'b0;
        #1;
        clr = 1'b1;
        cyc("after", 1, 0, 0, 0, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
